// File: rtl/gate_truth_table_scanner_pkg.sv
// gate_scan_pkg: shared states, expected truth table and gate bit positions for the scanner
package gate_scan_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, CAPTURE = 2'd2, CHECK = 2'd3} state_e;
  localparam logic [15:0] EXP_TRUTH_TBL = 16'h366C;
  localparam int AND_B = 0;
  localparam int OR_B = 1;
  localparam int NAND_B = 2;
  localparam int NOR_B = 3;
endpackage

// File: rtl/gate_truth_table_scanner_if.sv
// gate_truth_table_scanner_if: operand/result bus between the scanner (master) and the gate block (slave)
interface gate_truth_table_scanner_if;
  logic a_o, b_o, and_i, or_i, nand_i, nor_i;
  modport master(output a_o, b_o, input and_i, or_i, nand_i, nor_i);
  modport slave(input a_o, b_o, output and_i, or_i, nand_i, nor_i);
endinterface

// File: rtl/gate_truth_table_scanner_settle_timer.sv
// gate_scan_settle_timer: counts SETTLE_CYCLES enabled cycles after a load, flags the last one
module gate_scan_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);
  logic [3:0] r_cnt;
  assign expired = en && (r_cnt == 4'(SETTLE_CYCLES - 1));
  always_ff @(posedge clk)
    if (rst || load) r_cnt <= 4'd0;
    else if (en && !expired) r_cnt <= r_cnt + 4'd1;
endmodule

// File: rtl/gate_truth_table_scanner.sv
// gate_truth_table_scanner: sweeps a/b through the gate block and checks its truth table; GATE_SCAN_ERR_CNT_EN adds err_cnt
module gate_truth_table_scanner
  import gate_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  gate_truth_table_scanner_if.master        gate,
  output logic                              busy,
  output logic                              done,
  output logic [15:0]                       truth_tbl,
  output logic                              pass
`ifdef GATE_SCAN_ERR_CNT_EN
  ,
  output logic [7:0]                        err_cnt
`endif
);
  state_e      r_st;
  logic [1:0]  r_k;
  logic        r_a, r_b, r_done, r_pass;
  logic [15:0] r_tbl;
  logic        w_exp, w_load;
  logic [3:0]  w_nib;
  assign w_nib[AND_B]  = gate.and_i;
  assign w_nib[OR_B]   = gate.or_i;
  assign w_nib[NAND_B] = gate.nand_i;
  assign w_nib[NOR_B]  = gate.nor_i;
  assign gate.a_o = r_a;
  assign gate.b_o = r_b;
  assign busy = r_st != IDLE;
  assign done = r_done;
  assign truth_tbl = r_tbl;
  assign pass = r_pass;
  assign w_load = (r_st == IDLE && start) || (r_st == CAPTURE && r_k != 2'd3);
  gate_scan_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(w_load),
    .en(r_st == SETTLE),
    .expired(w_exp)
  );
  always_ff @(posedge clk)
    if (rst) begin
      r_st <= IDLE;
      r_k <= 2'd0;
      {r_a, r_b} <= 2'b00;
      r_done <= 1'b0;
      r_tbl <= 16'h0000;
      r_pass <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_st)
        IDLE: if (start) begin
          r_st <= SETTLE;
          r_k <= 2'd0;
          {r_a, r_b} <= 2'b00;
          r_tbl <= 16'h0000;
          r_pass <= 1'b0;
        end
        SETTLE: if (w_exp) r_st <= CAPTURE;
        CAPTURE: begin
          r_tbl[{r_k, 2'b00} +: 4] <= w_nib;
          if (r_k != 2'd3) begin
            r_k <= r_k + 2'd1;
            {r_a, r_b} <= r_k + 2'd1;
            r_st <= SETTLE;
          end else r_st <= CHECK;
        end
        CHECK: begin
          r_pass <= r_tbl == EXP_TRUTH_TBL;
          r_done <= 1'b1;
          {r_a, r_b} <= 2'b00;
          r_st <= IDLE;
        end
      endcase
    end
`ifdef GATE_SCAN_ERR_CNT_EN
  logic [7:0] r_err;
  assign err_cnt = r_err;
  always_ff @(posedge clk)
    if (rst) r_err <= 8'd0;
    else if (r_st == CHECK && r_tbl != EXP_TRUTH_TBL && r_err != 8'hFF) r_err <= r_err + 8'd1;
`endif
endmodule

// File: tb/tb_gate_truth_table_scanner.sv
// tb_gate_truth_table_scanner: randomized fault/timing scans checked against a cycle-level behavioural model
module tb_gate_truth_table_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1, st0 = 1'b0, st1 = 1'b0;
  logic busy0, done0, pass0, busy1, done1, pass1;
  logic [15:0] tbl0, tbl1;
`ifdef GATE_SCAN_ERR_CNT_EN
  logic [7:0] err0, err1;
`endif
  int n_chk = 0, n_fail = 0, e0 = 0, e1 = 0;
  logic f_en = 1'b0, f_val = 1'b0;
  int f_bit = 0, dly = 1;
  logic [1:0] h1 = 2'b00, h2 = 2'b00, w1;
  logic [1:0] o_ab[0:63];
  logic o_busy[0:63], o_done[0:63], o_pass[0:63];
  logic [15:0] o_tbl[0:63];
  int n_done, first_done;
  always #5 clk = ~clk;
  gate_truth_table_scanner_if g0(), g1();
  assign g0.and_i  = (f_en && f_bit == 0) ? f_val : (g0.a_o & g0.b_o);
  assign g0.or_i   = (f_en && f_bit == 1) ? f_val : (g0.a_o | g0.b_o);
  assign g0.nand_i = (f_en && f_bit == 2) ? f_val : ~(g0.a_o & g0.b_o);
  assign g0.nor_i  = (f_en && f_bit == 3) ? f_val : ~(g0.a_o | g0.b_o);
  always @(posedge clk) begin
    h1 <= {g1.a_o, g1.b_o};
    h2 <= h1;
  end
  assign w1 = dly == 2 ? h2 : h1;
  assign g1.and_i = w1[1] & w1[0];
  assign g1.or_i = w1[1] | w1[0];
  assign g1.nand_i = ~(w1[1] & w1[0]);
  assign g1.nor_i = ~(w1[1] | w1[0]);
  gate_truth_table_scanner dut0 (
    .clk(clk), .rst(rst), .start(st0), .gate(g0),
    .busy(busy0), .done(done0), .truth_tbl(tbl0), .pass(pass0)
`ifdef GATE_SCAN_ERR_CNT_EN
    , .err_cnt(err0)
`endif
  );
  gate_truth_table_scanner #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(st1), .gate(g1),
    .busy(busy1), .done(done1), .truth_tbl(tbl1), .pass(pass1)
`ifdef GATE_SCAN_ERR_CNT_EN
    , .err_cnt(err1)
`endif
  );

  // Which combination a_o/b_o present in cycle c of a scan (cycle 1 follows the start edge).
  function automatic int combo_at(input int c, input int s);
    if (c < 1) return 0;
    return ((c - 1) / (s + 1) > 3) ? 3 : (c - 1) / (s + 1);
  endfunction
  function automatic logic [3:0] nib(input int combo, input logic fe, input int fb, input logic fv);
    logic a, b;
    logic [3:0] n;
    a = combo[1];
    b = combo[0];
    n = {~(a | b), ~(a & b), a | b, a & b};
    if (fe) n[fb] = fv;
    return n;
  endfunction
  // Gates see a/b from d cycles earlier; capture of combo k happens in cycle (k+1)*(s+1).
  function automatic logic [15:0] model_tbl(input int s, input int d, input logic fe, input int fb, input logic fv);
    logic [15:0] t;
    for (int k = 0; k < 4; k++) t[4*k +: 4] = nib(combo_at((k + 1) * (s + 1) - d, s), fe, fb, fv);
    return t;
  endfunction

  task automatic scan(input int which, input int sa, input int sb, input int rst_c, input int ncyc);
    n_done = 0;
    first_done = 0;
    @(negedge clk);
    if (which == 0) st0 = 1'b1; else st1 = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      st0 = 1'b0;
      st1 = 1'b0;
      rst = 1'b0;
      o_ab[c] = which == 0 ? {g0.a_o, g0.b_o} : {g1.a_o, g1.b_o};
      o_busy[c] = which == 0 ? busy0 : busy1;
      o_done[c] = which == 0 ? done0 : done1;
      o_pass[c] = which == 0 ? pass0 : pass1;
      o_tbl[c] = which == 0 ? tbl0 : tbl1;
      if (o_done[c]) begin
        n_done++;
        if (first_done == 0) first_done = c;
      end
      if (c == sa || c == sb) begin
        if (which == 0) st0 = 1'b1; else st1 = 1'b1;
      end
      if (c == rst_c) rst = 1'b1;
    end
    st0 = 1'b0;
    st1 = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    e0 = 0;
    e1 = 0;
    n_chk++;
    if ({busy0, done0, pass0, g0.a_o, g0.b_o, tbl0} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset0: busy/done/pass/a/b/tbl got %b%b%b%b%b %h want all zero", busy0, done0, pass0, g0.a_o, g0.b_o, tbl0);
    end
    n_chk++;
    if ({busy1, done1, pass1, g1.a_o, g1.b_o, tbl1} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset1: busy/done/pass/a/b/tbl got %b%b%b%b%b %h want all zero", busy1, done1, pass1, g1.a_o, g1.b_o, tbl1);
    end
`ifdef GATE_SCAN_ERR_CNT_EN
    n_chk++;
    if ({err0, err1} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_err: got %0d/%0d want 0/0", err0, err1);
    end
`endif
  endtask

  task automatic test_ideal();
    logic [15:0] exp;
    exp = model_tbl(2, 0, 1'b0, 0, 1'b0);
    scan(0, 0, 0, 0, 16);
    n_chk++;
    if (first_done != 14 || n_done != 1) begin
      n_fail++;
      $display("FAIL ideal_done: got cycle %0d count %0d want cycle 14 count 1", first_done, n_done);
    end
    n_chk++;
    if (o_tbl[14] !== exp || o_pass[14] !== 1'b1) begin
      n_fail++;
      $display("FAIL ideal_tbl: got %h pass %b want %h pass 1", o_tbl[14], o_pass[14], exp);
    end
    for (int c = 1; c <= 14; c++) begin
      n_chk++;
      if (o_busy[c] !== (c != 14)) begin
        n_fail++;
        $display("FAIL ideal_busy c%0d: got %b want %b", c, o_busy[c], c != 14);
      end
    end
    n_chk++;
    if (o_tbl[16] !== exp || o_pass[16] !== 1'b1) begin
      n_fail++;
      $display("FAIL ideal_hold: got %h pass %b want %h pass 1", o_tbl[16], o_pass[16], exp);
    end
  endtask

  task automatic test_ab_sequence();
    logic [1:0] want;
    scan(0, 0, 0, 0, 16);
    for (int c = 1; c <= 16; c++) begin
      want = c >= 14 ? 2'd0 : 2'(combo_at(c, 2));
      n_chk++;
      if (o_ab[c] !== want) begin
        n_fail++;
        $display("FAIL ab_seq c%0d: got %b want %b", c, o_ab[c], want);
      end
    end
  endtask

  task automatic test_or_stuck();
    f_en = 1'b1;
    f_bit = 1;
    f_val = 1'b0;
    for (int r = 1; r <= 2; r++) begin
      scan(0, 0, 0, 0, 16);
      e0++;
      n_chk++;
      if (first_done != 14 || o_tbl[14] !== 16'h144C || o_pass[14] !== 1'b0) begin
        n_fail++;
        $display("FAIL or_stuck r%0d: done %0d tbl %h pass %b want 14 144c 0", r, first_done, o_tbl[14], o_pass[14]);
      end
`ifdef GATE_SCAN_ERR_CNT_EN
      n_chk++;
      if (err0 !== 8'(e0)) begin
        n_fail++;
        $display("FAIL or_stuck_err r%0d: got %0d want %0d", r, err0, e0);
      end
`endif
    end
    f_en = 1'b0;
  endtask

  task automatic test_ignored_start();
    scan(0, 3, 7, 0, 30);
    n_chk++;
    if (first_done != 14 || n_done != 1) begin
      n_fail++;
      $display("FAIL ignored_start: got first %0d count %0d want 14 1", first_done, n_done);
    end
    n_chk++;
    if (o_busy[20] !== 1'b0 || o_busy[30] !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_idle: busy got %b/%b want 0/0", o_busy[20], o_busy[30]);
    end
  endtask

  task automatic test_rst_mid();
    logic [15:0] exp;
    exp = model_tbl(2, 0, 1'b0, 0, 1'b0);
    scan(0, 0, 0, 6, 20);
    e0 = 0;
    e1 = 0;
    n_chk++;
    if ({o_busy[7], o_done[7], o_pass[7], o_ab[7], o_tbl[7]} !== 21'd0) begin
      n_fail++;
      $display("FAIL rst_mid_vals: busy %b done %b pass %b ab %b tbl %h want zeros", o_busy[7], o_done[7], o_pass[7], o_ab[7], o_tbl[7]);
    end
    n_chk++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL rst_mid_done: got %0d pulses want 0", n_done);
    end
`ifdef GATE_SCAN_ERR_CNT_EN
    n_chk++;
    if (err0 !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_mid_err: got %0d want 0", err0);
    end
`endif
    scan(0, 0, 0, 0, 16);
    n_chk++;
    if (first_done != 14 || o_tbl[14] !== exp || o_pass[14] !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_rescan: done %0d tbl %h pass %b want 14 %h 1", first_done, o_tbl[14], o_pass[14], exp);
    end
  endtask

  task automatic test_back_to_back();
    scan(0, 14, 0, 0, 30);
    n_chk++;
    if (n_done != 2 || first_done != 14 || o_done[28] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done: count %0d first %0d d28 %b want 2 14 1", n_done, first_done, o_done[28]);
    end
    n_chk++;
    if (o_busy[15] !== 1'b1 || o_tbl[15] !== 16'h0000 || o_tbl[28] !== 16'h366C) begin
      n_fail++;
      $display("FAIL b2b_tbl: busy15 %b tbl15 %h tbl28 %h want 1 0000 366c", o_busy[15], o_tbl[15], o_tbl[28]);
    end
  endtask

  task automatic test_delay();
    logic [15:0] exp;
    for (int d = 1; d <= 2; d++) begin
      dly = d;
      exp = model_tbl(1, d, 1'b0, 0, 1'b0);
      scan(1, 0, 0, 0, 14);
      if (exp != 16'h366C) e1++;
      n_chk++;
      if (first_done != 10 || o_tbl[10] !== exp || o_pass[10] !== (exp == 16'h366C)) begin
        n_fail++;
        $display("FAIL delay%0d: done %0d tbl %h pass %b want 10 %h %b", d, first_done, o_tbl[10], o_pass[10], exp, exp == 16'h366C);
      end
`ifdef GATE_SCAN_ERR_CNT_EN
      n_chk++;
      if (err1 !== 8'(e1)) begin
        n_fail++;
        $display("FAIL delay_err%0d: got %0d want %0d", d, err1, e1);
      end
`endif
    end
  endtask

  task automatic test_random_faults();
    logic [15:0] exp;
    for (int i = 0; i < 8; i++) begin
      f_en = 1'($urandom_range(1));
      f_bit = int'($urandom_range(3));
      f_val = 1'($urandom_range(1));
      exp = model_tbl(2, 0, f_en, f_bit, f_val);
      scan(0, 0, 0, 0, 16);
      if (exp != 16'h366C && e0 < 255) e0++;
      n_chk++;
      if (o_tbl[14] !== exp || o_pass[14] !== (exp == 16'h366C)) begin
        n_fail++;
        $display("FAIL rand%0d en %b bit %0d val %b: tbl %h pass %b want %h %b", i, f_en, f_bit, f_val, o_tbl[14], o_pass[14], exp, exp == 16'h366C);
      end
`ifdef GATE_SCAN_ERR_CNT_EN
      n_chk++;
      if (err0 !== 8'(e0)) begin
        n_fail++;
        $display("FAIL rand_err%0d: got %0d want %0d", i, err0, e0);
      end
`endif
    end
    f_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_ab_sequence();
    test_or_stuck();
    test_ignored_start();
    test_rst_mid();
    test_back_to_back();
    test_delay();
    test_random_faults();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gate_truth_table_scanner.md
Name: gate_truth_table_scanner

Overview:
Sequential stimulus-and-capture stage wrapped around the two-input demux gate generator (and/or/nand/nor).
- Upstream: drives the generator's a/b inputs through all four combinations.
- Downstream: samples the four gate outputs after a settle delay and packs them into a 16-bit truth table.
- Compares the table against the ideal value and reports pass/fail.
- Acts as the on-chip self-check stage for the gate block.

Parameters:
SETTLE_CYCLES, 2, cycles to hold each a/b combination before sampling; legal range 1..15.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request a scan; sampled only in IDLE
a_o  output  1  operand a to gate block
b_o  output  1  operand b to gate block
and_i  input  1  AND result from gate block
or_i  input  1  OR result from gate block
nand_i  input  1  NAND result from gate block
nor_i  input  1  NOR result from gate block
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse when scan result is valid
truth_tbl  output  16  captured table; nibble k = combination {a,b}=k; bit g within nibble: 0 and, 1 or, 2 nand, 3 nor
pass  output  1  truth_tbl equals 16'h366C; valid from done until next start
err_cnt  output  8  present only with the optional feature (see below)

Behaviour:
- Reset values: a_o=0, b_o=0, busy=0, done=0, truth_tbl=16'h0000, pass=0, state IDLE, combo index k=0, settle counter=0.
- FSM states: IDLE, SETTLE, CAPTURE, CHECK.
- IDLE, start=1: a_o/b_o<=0/0, k<=0, cnt<=0, truth_tbl<=0, pass<=0; go to SETTLE. IDLE, start=0: hold.
- SETTLE: cnt increments each cycle; after SETTLE_CYCLES cycles (cnt==SETTLE_CYCLES-1) go to CAPTURE.
- CAPTURE: truth_tbl[4k+3:4k] <= {nor_i,nand_i,or_i,and_i}.
  - If k<3: k<=k+1, {a_o,b_o}<=k+1, cnt<=0; go to SETTLE.
  - If k==3: go to CHECK.
- CHECK: pass<=(truth_tbl==16'h366C); done<=1 for exactly one cycle; a_o/b_o<=0; go to IDLE.
- Latency: done is high in cycle 4*(SETTLE_CYCLES+1)+2 counted from the edge that samples start. Default SETTLE_CYCLES=2 gives 14.
- busy is high from the cycle after start through the CHECK cycle, and is low in the cycle done is high.
- start while busy: ignored, no queuing.
- start in the same cycle done is high: accepted, because state is IDLE.
- rst mid-scan: immediate return to reset values; no done pulse; partial table discarded.
- truth_tbl and pass hold their values after done until the next accepted start.
- Combo order is fixed: {a,b}=00, 01, 10, 11. a_o/b_o are registered outputs only; no combinational path from inputs to outputs.

Optional Feature:
Macro GATE_SCAN_ERR_CNT_EN.
- Defined: err_cnt port exists, reset to 0. It increments by 1 in CHECK when the mismatch condition holds, saturates at 8'hFF, and is cleared only by rst.
- Not defined: err_cnt port and counter are absent; all other behaviour is identical.

Decomposition:
- Package gate_scan_pkg holds:
  - state enum (IDLE, SETTLE, CAPTURE, CHECK)
  - EXP_TRUTH_TBL = 16'h366C
  - gate bit indices AND_B=0, OR_B=1, NAND_B=2, NOR_B=3
- One sub-module, gate_scan_settle_timer: load/count/expire counter parameterised by SETTLE_CYCLES, instantiated once.
- FSM and capture logic stay in the top module.

Test Plan:
1. Ideal gate model on a/b, SETTLE_CYCLES=2, pulse start -> done at cycle 14, truth_tbl=16'h366C, pass=1, busy low at done.
2. or_i stuck at 0 -> truth_tbl=16'h144C, pass=0; with GATE_SCAN_ERR_CNT_EN, err_cnt=1, and 2 after a repeated scan.
3. start pulsed at cycles 3 and 7 of an active scan -> ignored; single done at cycle 14; next scan only after a new start in IDLE.
4. rst asserted at cycle 6 of a scan -> next cycle all outputs at reset values, no done; a fresh start then completes normally with 16'h366C.
5. SETTLE_CYCLES=1, gate outputs from an instance with 1-cycle registered delay -> done at cycle 10, pass=1. Same with SETTLE_CYCLES=1 and a 2-cycle delay -> pass=0.
6. Monitor a_o/b_o during a scan -> sequence 00, 01, 10, 11; each held exactly SETTLE_CYCLES+1 cycles; 00 after done.
